block_serializer_6144: RTL and testbench

Parallel-to-byte serializer for the coder/interleaver datapath. Captures a full 6144-bit or 1056-bit code block in one cycle and emits it as 8-bit bytes over a valid/ready stream. It is the read-side counterpart of the byte-wide input shift register that assembles blocks from a byte stream. Byte order is the inverse of that register's fill order, so a block assembled there and loaded here is re-emitted in its original byte order.

---
 rtl/block_serializer_6144.sv | 128 ++++++++++++
 tb/tb_block_serializer_6144.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_serializer_6144.sv
// Parallel-to-byte serializer: captures a 6144- or 1056-bit block in one cycle
// and emits it LSB byte first over a valid/ready byte stream.

module block_serializer_6144_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             ld,
  input  logic             sh,
  input  logic [VEC_W-1:0] ld_val,
  input  logic [VEC_W-1:0] sh_val,
  output logic [VEC_W-1:0] q
);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)  q <= '0;
    else if (ld)  q <= ld_val;
    else if (sh)  q <= sh_val;
  end

endmodule

module block_serializer_6144 (
  input  logic          clk,
  input  logic          aclr_n,
  input  logic          load,
  input  logic          size_sel,
  input  logic [6143:0] din,
  output logic          load_ready,
  output logic [7:0]    dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic [9:0]    byte_idx,
  output logic          done
);

  localparam int NUM_LANES   = 768;
  localparam int VEC_W       = 8;
  localparam int SHORT_LANES = 132;
  localparam int SHORT_BASE  = 5088;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state_q, state_d;
  logic [9:0] rem_q, idx_q;
  logic       done_q;
  logic       load_acc, xfer, last;

  logic [NUM_LANES-1:0][VEC_W-1:0] blk_q;

  assign load_acc = (state_q == IDLE) & load;
  assign xfer     = (state_q == SEND) & dout_ready;
  assign last     = (rem_q == 10'd0);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SEND;
      SEND:    if (dout_ready && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // remaining/byte_idx stop at the last byte so they never wrap.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      rem_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer & last;
      if (load_acc) begin
        rem_q <= size_sel ? 10'd767 : 10'd131;
        idx_q <= '0;
      end else if (xfer) begin
        if (!last) begin
          rem_q <= rem_q - 10'd1;
          idx_q <= idx_q + 10'd1;
        end else begin
          idx_q <= '0;
        end
      end
    end
  end

  // Byte lane k holds block byte k; lanes shift down toward lane 0 on transfer.
  // In 1056 mode only the low 132 lanes are filled, from din[6143:5088].
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [VEC_W-1:0] ld_val, sh_val;

    if (k < SHORT_LANES) begin : g_short
      assign ld_val = size_sel ? din[k*VEC_W +: VEC_W] : din[SHORT_BASE + k*VEC_W +: VEC_W];
    end else begin : g_long
      assign ld_val = size_sel ? din[k*VEC_W +: VEC_W] : '0;
    end

    if (k == NUM_LANES-1) begin : g_top
      assign sh_val = '0;
    end else begin : g_mid
      assign sh_val = blk_q[k+1];
    end

    block_serializer_6144_lane #(.VEC_W(VEC_W)) u_lane (
      .clk    (clk),
      .aclr_n (aclr_n),
      .ld     (load_acc),
      .sh     (xfer),
      .ld_val (ld_val),
      .sh_val (sh_val),
      .q      (blk_q[k])
    );
  end

  assign load_ready = (state_q == IDLE);
  assign dout_valid = (state_q == SEND);
  assign dout_last  = (state_q == SEND) & last;
  assign dout       = (state_q == SEND) ? blk_q[0] : 8'h00;
  assign byte_idx   = (state_q == SEND) ? idx_q : 10'd0;
  assign done       = done_q;

endmodule

// File: tb/tb_block_serializer_6144.sv
// Self-checking bench for block_serializer_6144 with a byte-queue reference model.

module tb_block_serializer_6144;

  logic          clk, aclr_n, load, size_sel, dout_ready;
  logic [6143:0] din;
  logic          load_ready, dout_valid, dout_last, done;
  logic [7:0]    dout;
  logic [9:0]    byte_idx;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_b[$];
  int         got_i[$];
  bit         got_l[$];
  int         done_cnt, nvalid, hold_err;
  bit         timeout;
  logic       done_after, valid_after, lr_after;

  block_serializer_6144 dut (
    .clk(clk), .aclr_n(aclr_n), .load(load), .size_sel(size_sel), .din(din),
    .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .byte_idx(byte_idx), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: block byte k is din[base+8k +: 8], emitted in increasing k.
  task automatic build_exp(input logic [6143:0] d, input logic sz);
    int n, base;
    n = sz ? 768 : 132;
    base = sz ? 0 : 5088;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(d[base + 8*k +: 8]);
  endtask

  function automatic logic [6143:0] rand_blk();
    logic [6143:0] d;
    for (int k = 0; k < 192; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // -1: all match, -2: wrong length, else first differing byte position.
  function automatic int first_bad(input int n);
    if (got_b.size() != n || exp_q.size() != n) return -2;
    for (int k = 0; k < n; k++)
      if (got_b[k] !== exp_q[k] || got_i[k] != k || got_l[k] != (k == n-1)) return k;
    return -1;
  endfunction

  task automatic start_load(input logic [6143:0] d, input logic sz);
    @(negedge clk);
    load = 1'b1; size_sel = sz; din = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Drains one block from the current negedge; mode 0 ready=1, 1 toggling, 2 random.
  task automatic collect(input int mode, input int load_at);
    int budget;
    bit fin, stalled, rdy, pl;
    logic [7:0] pb;
    logic [9:0] pi;
    got_b.delete(); got_i.delete(); got_l.delete();
    done_cnt = 0; nvalid = 0; hold_err = 0;
    fin = 0; stalled = 0; budget = 4000; rdy = (mode == 1) ? 1'b1 : 1'b0;
    pb = '0; pi = '0; pl = 0;
    while (!fin && budget > 0) begin
      if (done) done_cnt++;
      if (dout_valid) begin
        nvalid++;
        if (stalled && (dout !== pb || byte_idx !== pi || dout_last !== pl)) hold_err++;
        if (load_at >= 0) begin
          if (got_b.size() == load_at) begin load = 1'b1; din = ~din; end
          else load = 1'b0;
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ~rdy;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        dout_ready = rdy;
        if (rdy) begin
          got_b.push_back(dout);
          got_i.push_back(int'(byte_idx));
          got_l.push_back(dout_last);
          if (dout_last) fin = 1;
        end
        stalled = !rdy; pb = dout; pi = byte_idx; pl = dout_last;
      end
      @(negedge clk);
      budget--;
    end
    if (load_at >= 0) load = 1'b0;
    dout_ready = 1'b1;
    timeout = !fin;
    done_after = done; valid_after = dout_valid; lr_after = load_ready;
  endtask

  task automatic tail(input int n);
    repeat (n) begin
      dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) done_cnt++;
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    aclr_n = 1'b1; load = 0; size_sel = 0; dout_ready = 1; din = '0;
    #1 aclr_n = 1'b0;
    #2;
    checks++;
    if ({load_ready, dout_valid, dout_last, done, dout, byte_idx} !== {4'b1000, 8'h00, 10'd0})
      $display("FAIL reset_state got=%b exp=%b",
               {load_ready, dout_valid, dout_last, done, dout, byte_idx}, {4'b1000, 18'd0});
    @(negedge clk); aclr_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_ready, dout_valid, done} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=100", {load_ready, dout_valid, done});
    end
  endtask

  task automatic test_6144_inc();
    logic [6143:0] d;
    int fb;
    for (int k = 0; k < 768; k++) d[8*k +: 8] = 8'(k);
    exp_q.delete();
    for (int k = 0; k < 768; k++) exp_q.push_back(8'(k % 256));
    start_load(d, 1'b1);
    checks++;
    if ({dout_valid, load_ready, byte_idx} !== {2'b10, 10'd0}) begin
      failures++;
      $display("FAIL load_latency got=%b exp=%b", {dout_valid, load_ready, byte_idx}, {2'b10, 10'd0});
    end
    collect(0, -1);
    checks++;
    fb = first_bad(768);
    if (timeout || fb != -1) begin
      failures++;
      $display("FAIL inc6144_stream got=pos%0d/len%0d exp=pos-1/len768", fb, got_b.size());
    end
    checks++;
    if (nvalid != 768) begin
      failures++;
      $display("FAIL inc6144_duration got=%0d exp=768", nvalid);
    end
    checks++;
    if ({done_after, valid_after, lr_after} !== 3'b101) begin
      failures++;
      $display("FAIL inc6144_done got=%b exp=101", {done_after, valid_after, lr_after});
    end
    tail(4);
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL inc6144_single_done got=%0d exp=0 extra", done_cnt);
    end
  endtask

  task automatic test_1056();
    logic [6143:0] d;
    int fb;
    d = '1;
    for (int k = 0; k < 132; k++) d[5088 + 8*k +: 8] = 8'(8'hA0 + k);
    for (int mode = 0; mode < 2; mode++) begin
      exp_q.delete();
      for (int k = 0; k < 132; k++) exp_q.push_back(8'(160 + k));
      start_load(d, 1'b0);
      collect(mode, -1);
      checks++;
      fb = first_bad(132);
      if (timeout || fb != -1) begin
        failures++;
        $display("FAIL s1056_stream_m%0d got=pos%0d/len%0d exp=pos-1/len132", mode, fb, got_b.size());
      end
      checks++;
      if (hold_err != 0 || (mode == 0 && nvalid != 132)) begin
        failures++;
        $display("FAIL s1056_hold_m%0d got=holderr%0d/valid%0d exp=0/132", mode, hold_err, nvalid);
      end
      checks++;
      if (done_after !== 1'b1) begin
        failures++;
        $display("FAIL s1056_done_m%0d got=%b exp=1", mode, done_after);
      end
    end
  endtask

  task automatic test_load_ignored();
    logic [6143:0] d;
    int fb, total;
    d = rand_blk();
    build_exp(d, 1'b1);
    start_load(d, 1'b1);
    collect(0, 100);
    checks++;
    fb = first_bad(768);
    if (timeout || fb != -1) begin
      failures++;
      $display("FAIL load_in_send_stream got=pos%0d/len%0d exp=pos-1/len768", fb, got_b.size());
    end
    total = done_cnt + int'(done_after);
    tail(4);
    total += done_cnt;
    checks++;
    if (total != 1) begin
      failures++;
      $display("FAIL load_in_send_done got=%0d exp=1", total);
    end
  endtask

  task automatic test_reset_mid();
    logic [6143:0] d;
    int budget, fb;
    d = rand_blk();
    start_load(d, 1'b1);
    dout_ready = 1'b1;
    budget = 200;
    while (byte_idx != 10'd50 && budget > 0) begin @(negedge clk); budget--; end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL reach_byte50 got=%0d exp=50", byte_idx);
    end
    #2 aclr_n = 1'b0;
    #1;
    checks++;
    if ({load_ready, dout_valid, dout_last, done, dout, byte_idx} !== {4'b1000, 8'h00, 10'd0}) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b",
               {load_ready, dout_valid, dout_last, done, dout, byte_idx}, {4'b1000, 18'd0});
    end
    @(negedge clk); aclr_n = 1'b1;
    done_cnt = 0;
    tail(4);
    checks++;
    if (done_cnt != 0 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done got=%0d/%b exp=0/0", done_cnt, dout_valid);
    end
    d = rand_blk();
    build_exp(d, 1'b0);
    start_load(d, 1'b0);
    collect(2, -1);
    checks++;
    fb = first_bad(132);
    if (timeout || fb != -1) begin
      failures++;
      $display("FAIL restart_stream got=pos%0d/len%0d exp=pos-1/len132", fb, got_b.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [6143:0] d1, d2;
    int fb;
    d1 = rand_blk(); d2 = rand_blk();
    @(negedge clk);
    load = 1'b1; size_sel = 1'b0; din = d1;
    @(negedge clk);
    build_exp(d1, 1'b0);
    collect(0, -1);
    checks++;
    fb = first_bad(132);
    if (timeout || fb != -1 || done_cnt != 0) begin
      failures++;
      $display("FAIL b2b_first got=pos%0d/done%0d exp=pos-1/done0", fb, done_cnt);
    end
    checks++;
    if ({done_after, valid_after} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_idle_gap got=%b exp=10", {done_after, valid_after});
    end
    din = d2;
    @(negedge clk);
    checks++;
    if ({dout_valid, byte_idx} !== {1'b1, 10'd0}) begin
      failures++;
      $display("FAIL b2b_restart got=%b exp=%b", {dout_valid, byte_idx}, {1'b1, 10'd0});
    end
    load = 1'b0;
    build_exp(d2, 1'b0);
    collect(0, -1);
    checks++;
    fb = first_bad(132);
    if (timeout || fb != -1) begin
      failures++;
      $display("FAIL b2b_second got=pos%0d/len%0d exp=pos-1/len132", fb, got_b.size());
    end
  endtask

  task automatic test_round_trip();
    logic [6143:0] sr;
    logic [7:0] src[$];
    int fb;
    sr = '0;
    for (int k = 0; k < 768; k++) src.push_back(8'($urandom));
    // Input shift register: each new byte enters at the top, oldest ends at [7:0].
    foreach (src[k]) sr = {src[k], sr[6143:8]};
    exp_q = src;
    start_load(sr, 1'b1);
    collect(2, -1);
    checks++;
    fb = first_bad(768);
    if (timeout || fb != -1) begin
      failures++;
      $display("FAIL round_trip got=pos%0d/len%0d exp=pos-1/len768", fb, got_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_6144_inc();
    test_1056();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
